// File: rtl/pico_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pico_fetch_pkg
// Brief    : Shared types, default widths and PC arithmetic for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package pico_fetch_pkg;

    localparam int unsigned PSIZE = 6;
    localparam int unsigned ISIZE = 20;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Sign-extends the low `width` bits of offset and adds them to pc; the
    // caller truncates the result back to its PC width for modulo wrap.
    function automatic logic [31:0] pc_rel_target(input logic [31:0]   pc,
                                                   input logic [31:0]   offset,
                                                   input int unsigned   width);
        logic [31:0] sext;
        sext = 32'($signed(offset << (32 - width)) >>> (32 - width));
        return pc + sext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : fetch_perf_counters
// Brief    : Saturating retired-instruction and taken-branch event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_perf_counters #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_instr_evt,
    input  logic          i_branch_evt,
    output logic [CW-1:0] o_instr_count,
    output logic [CW-1:0] o_branch_count
);

    logic [CW-1:0] instr_count_q, instr_count_d;
    logic [CW-1:0] branch_count_q, branch_count_d;

    always_comb begin
        instr_count_d  = instr_count_q;
        branch_count_d = branch_count_q;
        if (i_instr_evt && (instr_count_q != '1))
            instr_count_d = instr_count_q + CW'(1);
        if (i_branch_evt && (branch_count_q != '1))
            branch_count_d = branch_count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_q  <= '0;
            branch_count_q <= '0;
        end else begin
            instr_count_q  <= instr_count_d;
            branch_count_q <= branch_count_d;
        end
    end

    assign o_instr_count  = instr_count_q;
    assign o_branch_count = branch_count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : mypicoMIPS fetch stage: PC, boot/run/halt sequencing, ROM address.
//            Define PICO_FETCH_PERF_EN to add instr_count/branch_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import pico_fetch_pkg::*;
#(
    parameter int unsigned Psize = PSIZE,
    parameter int unsigned Isize = ISIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             PCincr,
    input  logic             PCrelbranch,
    input  logic [Psize-1:0] Branchaddr,
    output logic [Psize-1:0] rom_addr,
    input  logic [Isize-1:0] rom_data,
    output logic [Isize-1:0] instr,
    output logic             instr_valid,
    output logic [Psize-1:0] pc_out,
`ifdef PICO_FETCH_PERF_EN
    output logic [15:0]      instr_count,
    output logic [15:0]      branch_count,
`endif
    output logic             halted
);

    fetch_state_t     state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             halted_q, halted_d;

    // rom_addr always tracks the PC that will be current after the next edge,
    // so the synchronous ROM delivers that word with no bubble.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rom_addr = pc_q;
        case (state_q)
            BOOT: begin
                state_d  = RUN;
                pc_d     = '0;
                rom_addr = '0;
            end
            RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (PCrelbranch && (Branchaddr == '0)) begin
                    state_d = HALT;
                end else if (PCrelbranch) begin
                    pc_d = Psize'(pc_rel_target(32'(pc_q), 32'(Branchaddr), Psize));
                end else if (PCincr) begin
                    pc_d = pc_q + Psize'(1);
                end
                rom_addr = pc_d;
            end
            HALT: begin
                rom_addr = pc_q;
            end
            default: begin
                state_d  = BOOT;
                pc_d     = '0;
                rom_addr = '0;
            end
        endcase
        instr_valid_d = (state_d == RUN);
        halted_d      = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign instr       = rom_data;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_q;
    assign halted      = halted_q;

`ifdef PICO_FETCH_PERF_EN
    logic count_instr;
    logic count_branch;

    assign count_instr  = (state_q == RUN) && !stall;
    assign count_branch = count_instr && PCrelbranch && (Branchaddr != '0);

    fetch_perf_counters #(
        .CW (16)
    ) u_perf (
        .clk            (clk),
        .reset          (reset),
        .i_instr_evt    (count_instr),
        .i_branch_evt   (count_branch),
        .o_instr_count  (instr_count),
        .o_branch_count (branch_count)
    );
`endif

endmodule
`default_nettype wire
